// File: rtl/fifo_4deep_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_4deep_if : producer/consumer handshake bundle for fifo_4deep     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface fifo_4deep_if #(
   parameter int WIDTH = 32
);
   logic             push;
   logic [WIDTH-1:0] data_in;
   logic             pop;
   logic [WIDTH-1:0] data_out;
   logic             fifo_full;
   logic             fifo_empty;

   modport master (
      output push, data_in, pop,
      input  data_out, fifo_full, fifo_empty
   );

   modport slave (
      input  push, data_in, pop,
      output data_out, fifo_full, fifo_empty
   );
endinterface
`default_nettype wire

// File: rtl/fifo_4deep.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_4deep : single-clock FIFO, registered read data and status flags |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fifo_4deep #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   fifo_4deep_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             push_acc;
   logic             pop_acc;

   always_comb begin
      pop_acc  = bus.pop && !empty_q;
      // a pop in the same cycle frees a slot, so a full FIFO still takes the push
      push_acc = bus.push && (!full_q || pop_acc);

      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      dout_d = dout_q;

      if (push_acc) begin
         mem_d[wptr_q] = bus.data_in;
         wptr_d        = wptr_q + AW'(1);
      end

      if (pop_acc) begin
         dout_d = mem_q[rptr_q];
         rptr_d = rptr_q + AW'(1);
      end

      case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // storage contents are don't-care after reset, so no reset term here
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.data_out   = dout_q;
   assign bus.fifo_full  = full_q;
   assign bus.fifo_empty = empty_q;
endmodule
`default_nettype wire

// File: tb/tb_fifo_4deep.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_4deep : directed + random bench with queue reference model    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_fifo_4deep;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   logic [WIDTH-1:0] model_q [$];
   logic [WIDTH-1:0] exp_dout;

   fifo_4deep_if #(.WIDTH(WIDTH)) bus ();

   fifo_4deep #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_dout"},  bus.data_out, exp_dout);
      check({tag, "_full"},  32'(bus.fifo_full),  32'(model_q.size() == DEPTH));
      check({tag, "_empty"}, 32'(bus.fifo_empty), 32'(model_q.size() == 0));
   endtask

   // One clock cycle of stimulus; the model applies the FIFO rules on a queue.
   task automatic step(input string tag, input logic ps, input logic pp, input logic [31:0] d);
      bit pop_ok;
      bit push_ok;
      bus.push    = ps;
      bus.pop     = pp;
      bus.data_in = d;
      pop_ok  = pp && (model_q.size() > 0);
      push_ok = ps && ((model_q.size() < DEPTH) || pop_ok);
      if (pop_ok)  exp_dout = model_q.pop_front();
      if (push_ok) model_q.push_back(d);
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      check_all(tag);
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      exp_dout    = '0;
      reset       = 1'b0;
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
      bus.data_in = '0;

      // reset held for one cycle, released away from the edge
      @(posedge clk);
      #1;
      check_all("in_reset");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_all("post_reset");

      // fill
      step("fill1", 1'b1, 1'b0, 32'h1111_1111);
      check("fill1_empty_fell", 32'(bus.fifo_empty), 32'd0);
      step("fill2", 1'b1, 1'b0, 32'h2222_2222);
      step("fill3", 1'b1, 1'b0, 32'h3333_3333);
      step("fill4", 1'b1, 1'b0, 32'h4444_4444);
      check("fill4_full_rose", 32'(bus.fifo_full), 32'd1);

      // overflow ignored, then drain in order
      step("overflow", 1'b1, 1'b0, 32'hDEAD_BEEF);
      step("drain1", 1'b0, 1'b1, 32'h0);
      check("drain1_val", bus.data_out, 32'h1111_1111);
      step("drain2", 1'b0, 1'b1, 32'h0);
      step("drain3", 1'b0, 1'b1, 32'h0);
      step("drain4", 1'b0, 1'b1, 32'h0);
      check("drain4_val", bus.data_out, 32'h4444_4444);
      check("drain4_empty", 32'(bus.fifo_empty), 32'd1);

      // underflow and push+pop on empty
      step("underflow", 1'b0, 1'b1, 32'h0);
      check("underflow_hold", bus.data_out, 32'h4444_4444);
      step("pp_empty", 1'b1, 1'b1, 32'hCAFE_0001);
      check("pp_empty_no_wt", bus.data_out, 32'h4444_4444);
      step("pp_empty_pop", 1'b0, 1'b1, 32'h0);

      // full plus simultaneous push/pop
      for (int i = 1; i <= 4; i++) step("full_fill", 1'b1, 1'b0, 32'(i));
      step("full_pp", 1'b1, 1'b1, 32'd5);
      check("full_pp_val", bus.data_out, 32'd1);
      check("full_pp_full", 32'(bus.fifo_full), 32'd1);
      for (int i = 0; i < 4; i++) step("full_drain", 1'b0, 1'b1, 32'h0);
      check("full_drain_last", bus.data_out, 32'd5);

      // wrap: 4 pushes, 1 pop, 1 push per iteration
      for (int it = 0; it < 10; it++) begin
         for (int k = 0; k < 4; k++) step("wrap_push", 1'b1, 1'b0, $urandom);
         step("wrap_pop", 1'b0, 1'b1, 32'h0);
         step("wrap_push2", 1'b1, 1'b0, $urandom);
      end

      // random mix of strobes
      for (int n = 0; n < 200; n++) begin
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end

      // make sure there is state to clear, then reset mid-stream
      step("pre_rst", 1'b1, 1'b1, 32'hA5A5_5A5A);
      step("pre_rst2", 1'b1, 1'b0, 32'h0F0F_F0F0);
      bus.push    = 1'b1;
      bus.data_in = 32'h7777_7777;
      reset       = 1'b0;
      #1;
      model_q.delete();
      exp_dout = '0;
      check_all("async_rst");
      bus.push = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_all("after_rst");
      step("after_rst_push", 1'b1, 1'b0, 32'h1234_5678);
      step("after_rst_pop", 1'b0, 1'b1, 32'h0);
      check("after_rst_val", bus.data_out, 32'h1234_5678);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fifo_4deep.md
# fifo_4deep

Synchronous first-in/first-out buffer, 4 entries of 32 bits by default, with single-cycle push and pop strobes and registered full/empty status. It decouples a producer that writes words on `push` from a consumer that reads them on `pop`, within a single clock domain. Overflow and underflow attempts are silently ignored, so neither side can corrupt the stored data.

## Interface
- `WIDTH`, default 32: data word width in bits.
- `DEPTH`, default 4: number of storage entries; must be a power of two, 2 or greater.

- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserting it low clears all state immediately. Release is sampled synchronously to `clk`.
- `push` input 1: write strobe; stores `data_in` at a rising edge when accepted.
- `data_in` input WIDTH: write data.
- `pop` input 1: read strobe; removes the oldest entry at a rising edge when accepted.
- `data_out` output WIDTH: registered read data; holds the word most recently popped.
- `fifo_full` output 1: high when the FIFO holds DEPTH entries.
- `fifo_empty` output 1: high when the FIFO holds 0 entries.

## Operation
- State:
  - Storage array `mem[DEPTH]`.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy `count`, log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (`reset` = 0):
  - Pointers = 0, `count` = 0, `data_out` = 0.
  - `fifo_empty` = 1, `fifo_full` = 0.
  - Storage contents are don't-care.
- Push accepted when `push` = 1 and either `count` < DEPTH, or `pop` is accepted in the same cycle. On accept: `mem[wptr]` <= `data_in`, then wptr increments.
- Pop accepted when `pop` = 1 and `count` > 0. On accept: `data_out` <= `mem[rptr]`, then rptr increments.
- `data_out` holds its value in every cycle without an accepted pop.
- `count` update per cycle:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both or neither are accepted.
- Flags: `fifo_full` = (`count` == DEPTH); `fifo_empty` = (`count` == 0). Both are derived from the registered `count`, so they are glitch-free.
- Boundary cases:
  - Push while full and no pop: ignored; storage and pointers unchanged.
  - Pop while empty: ignored; `data_out` holds its value.
  - Push and pop while empty: only the push is accepted; `count` goes 0 -> 1. No write-through to `data_out`.
  - Push and pop while full: both are accepted; the oldest word is popped, the new word is written into the freed slot, and `count` stays at DEPTH.
  - Pointer wrap: DEPTH-1 -> 0 with no loss of ordering.
- Ordering: words leave in exactly the order they were accepted.

## Timing
- Push latency: the word is stored at the accepting edge. `fifo_empty` falls immediately after that edge. The word becomes poppable in the next cycle.
- Pop latency: `data_out` shows the popped word immediately after the accepting edge, i.e. one cycle after `pop` is sampled.
- Flags reflect the post-edge `count` and are updated in the same edge as the operation.
- `push` and `pop` are level-sampled at each rising edge. Holding a strobe high for N cycles performs N operations, subject to full/empty gating.
- Reset asserted mid-operation: all outputs go to their reset values asynchronously; any in-flight push or pop is discarded.

## Test plan
- Reset: hold `reset` = 0 for 1 cycle, then release -> `fifo_empty` = 1, `fifo_full` = 0, `data_out` = 0.
- Fill: push 0x11111111, 0x22222222, 0x33333333, 0x44444444 in separate cycles -> `fifo_empty` falls after the first push; `fifo_full` rises after the fourth.
- Overflow: a 5th push of 0xDEADBEEF while full and no pop -> ignored. Then 4 pops -> `data_out` = 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order; `fifo_empty` = 1 after the last pop.
- Underflow: pop while empty -> `data_out` holds 0x44444444; flags unchanged.
- Full plus simultaneous push/pop: with the FIFO full of 1..4, push 5 and pop in the same cycle -> `data_out` = 1 and `fifo_full` stays 1. Then drain -> 2, 3, 4, 5.
- Wrap and reset: 10 iterations of 4 pushes of random data, 1 pop and 1 push. Every popped value must match a reference queue and `count` must never exceed 4. Then assert `reset` mid-stream -> outputs go to reset values immediately.
